// File: rtl/smc_rdata_lite_pkg.sv
// Shared size codes, FSM encodings and access-count helper for the lite SMC
// read-data path.
package smc_rdata_lite_pkg;

  localparam logic [1:0] XSIZ_8  = 2'b00;
  localparam logic [1:0] XSIZ_16 = 2'b01;
  localparam logic [1:0] XSIZ_32 = 2'b10;

  localparam logic [1:0] BSIZ_8  = 2'b00;
  localparam logic [1:0] BSIZ_16 = 2'b01;
  localparam logic [1:0] BSIZ_32 = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Reserved code 2'b11 behaves as a 32-bit size
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? 2'b10 : s;
  endfunction

  function automatic logic [2:0] acc_count(input logic [1:0] xs, input logic [1:0] bs);
    logic [1:0] x;
    logic [1:0] b;
    x = norm_size(xs);
    b = norm_size(bs);
    if (x == XSIZ_32 && b == BSIZ_8)  return 3'd4;
    if (x == XSIZ_32 && b == BSIZ_16) return 3'd2;
    if (x == XSIZ_16 && b == BSIZ_8)  return 3'd2;
    return 3'd1;
  endfunction

endpackage

// File: rtl/smc_rdata_lite_if.sv
// EMI-side read-return bus into the assembler and the assembled AHB-side result.
interface smc_rdata_lite_if #(parameter int DW = 32);
  logic          valid_access;
  logic [1:0]    v_xfer_size;
  logic [1:0]    v_bus_size;
  logic [1:0]    smc_addr_lsb;
  logic          rd_strobe;
  logic [DW-1:0] data_smc;
  logic          smc_done;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          busy;
  logic          rd_err;

  modport master (
    output valid_access, v_xfer_size, v_bus_size, smc_addr_lsb,
           rd_strobe, data_smc, smc_done,
    input  read_data, read_valid, busy, rd_err
  );

  modport slave (
    input  valid_access, v_xfer_size, v_bus_size, smc_addr_lsb,
           rd_strobe, data_smc, smc_done,
    output read_data, read_valid, busy, rd_err
  );
endinterface

// File: rtl/smc_rdata_lane_lite.sv
// Combinational lane steering: replicates narrow data across lanes and produces
// the byte enables for the lane(s) addressed by the EMI LSBs.
module smc_rdata_lane_lite
  import smc_rdata_lite_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    i_bus_size,
  input  logic [1:0]    i_xfer_size,
  input  logic [1:0]    i_addr_lsb,
  input  logic [DW-1:0] i_data,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_data
);

  always_comb begin
    o_be   = 4'b1111;
    o_data = i_data;
    case (i_bus_size)
      BSIZ_8: begin
        o_be   = 4'b0001 << i_addr_lsb;
        o_data = {4{i_data[7:0]}};
      end
      BSIZ_16: begin
        o_be   = i_addr_lsb[1] ? 4'b1100 : 4'b0011;
        o_data = {2{i_data[15:0]}};
      end
      default: begin
        // Full-width bus: data is already lane-aligned, only mask by transfer size
        case (i_xfer_size)
          XSIZ_8:  o_be = 4'b0001 << i_addr_lsb;
          XSIZ_16: o_be = i_addr_lsb[1] ? 4'b1100 : 4'b0011;
          default: o_be = 4'b1111;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/smc_rdata_lite.sv
// Read-data assembler: collects 1, 2 or 4 EMI accesses into one AHB word and
// pulses read_valid the cycle after the final strobe.
module smc_rdata_lite
  import smc_rdata_lite_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 3
) (
  input  logic             sys_clk,
  input  logic             n_sys_reset,
  smc_rdata_lite_if.slave  bus
);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_acc;
  logic [1:0]    r_xsz;
  logic [1:0]    r_bsz;
  logic          r_err;

  logic [3:0]    w_be;
  logic [DW-1:0] w_steer;
  logic [DW-1:0] w_mask;
  logic          w_rsv;

  smc_rdata_lane_lite #(.DW(DW)) u_lane (
    .i_bus_size  (r_bsz),
    .i_xfer_size (r_xsz),
    .i_addr_lsb  (bus.smc_addr_lsb),
    .i_data      (bus.data_smc),
    .o_be        (w_be),
    .o_data      (w_steer)
  );

  assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_rsv  = (bus.v_xfer_size == 2'b11) || (bus.v_bus_size == 2'b11);

  always_ff @(posedge sys_clk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_xsz   <= '0;
      r_bsz   <= '0;
      r_err   <= 1'b0;
    end else if (bus.valid_access) begin
      // A new transfer always wins, discarding any coincident strobe
      r_state <= ST_COLLECT;
      r_cnt   <= CW'(acc_count(bus.v_xfer_size, bus.v_bus_size));
      r_acc   <= '0;
      r_xsz   <= norm_size(bus.v_xfer_size);
      r_bsz   <= norm_size(bus.v_bus_size);
      r_err   <= w_rsv || bus.rd_strobe;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (bus.rd_strobe) begin
            r_acc <= (r_acc & ~w_mask) | (w_steer & w_mask);
            r_cnt <= r_cnt - 1'b1;
          end
          if (bus.rd_strobe && r_cnt == CW'(1)) begin
            r_state <= ST_DONE;
          end else if (bus.smc_done) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_err   <= bus.rd_strobe;
        end
        default: begin
          r_state <= ST_IDLE;
          r_err   <= bus.rd_strobe;
        end
      endcase
    end
  end

  assign bus.read_data  = r_acc;
  assign bus.read_valid = (r_state == ST_DONE);
  assign bus.busy       = (r_state == ST_COLLECT);
  assign bus.rd_err     = r_err;

endmodule
